led_pattern_driver: RTL

- Output-side companion to the front-panel button debouncer. It drives one user LED with a selectable pattern: off, steady on, slow blink, fast blink, or an N-pulse blink code.
- The pattern is gated by a 4-bit PWM brightness.
- Configuration is latched on a one-cycle load strobe from the system-control logic.
- It emits a period-done pulse so firmware or other logic can synchronise to the pattern.

---
 rtl/led_pattern_driver_pkg.sv | 51 +++++
 rtl/led_pattern_driver_if.sv | 21 ++
 rtl/led_tick_prescaler.sv | 33 +++
 rtl/led_pattern_driver.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/led_pattern_driver_pkg.sv
// Shared definitions for the front-panel LED pattern driver: mode encodings,
// pattern FSM states, default timing constants and small helpers.
package led_pattern_driver_pkg;

  typedef enum logic [2:0] {
    MODE_OFF  = 3'd0,
    MODE_ON   = 3'd1,
    MODE_SLOW = 3'd2,
    MODE_FAST = 3'd3,
    MODE_CODE = 3'd4
  } led_mode_e;

  typedef enum logic [2:0] {
    S_STATIC,
    S_BLINK,
    S_CODE_ON,
    S_CODE_OFF,
    S_CODE_GAP
  } led_state_e;

  typedef struct packed {
    logic [2:0] mode;
    logic [3:0] code_len;
    logic [3:0] brightness;
  } led_cfg_t;

  localparam int DEF_TICK_DIV    = 50000;
  localparam int DEF_SLOW_HALF   = 500;
  localparam int DEF_FAST_HALF   = 125;
  localparam int DEF_PULSE_TICKS = 200;
  localparam int DEF_GAP_TICKS   = 1000;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Unknown modes and an empty code both fall back to the dark static state.
  function automatic led_state_e start_state(input logic [2:0] mode, input logic [3:0] code_len);
    case (mode)
      MODE_SLOW, MODE_FAST: return S_BLINK;
      MODE_CODE:            return (code_len != 4'd0) ? S_CODE_ON : S_STATIC;
      default:              return S_STATIC;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_driver_if.sv
// Configuration/status bundle between system-control logic (master) and the
// LED pattern driver (slave).
interface led_pattern_driver_if ();
  logic       load;
  logic [2:0] mode;
  logic [3:0] code_len;
  logic [3:0] brightness;
  logic       led;
  logic       period_done;
  logic [2:0] cur_mode;

  modport master (
    output load, mode, code_len, brightness,
    input  led, period_done, cur_mode
  );

  modport slave (
    input  load, mode, code_len, brightness,
    output led, period_done, cur_mode
  );
endinterface

// File: rtl/led_tick_prescaler.sv
// Free-running clk divider producing a one-cycle tick every TICK_DIV cycles;
// clear restarts the count from zero. Shared by the front-panel blocks.
module led_tick_prescaler
  import led_pattern_driver_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_pattern_driver.sv
// Drives one user LED with a selectable off/on/blink/blink-code pattern,
// gated by a 4-bit PWM brightness, with a period-done pulse for sync.
module led_pattern_driver
  import led_pattern_driver_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int SLOW_HALF   = DEF_SLOW_HALF,
  parameter int FAST_HALF   = DEF_FAST_HALF,
  parameter int PULSE_TICKS = DEF_PULSE_TICKS,
  parameter int GAP_TICKS   = DEF_GAP_TICKS
) (
  input logic                 clk,
  input logic                 reset,
  led_pattern_driver_if.slave bus
);

  localparam int PHASE_W = $clog2(max_of4(SLOW_HALF, FAST_HALF, PULSE_TICKS, GAP_TICKS)) + 1;

  localparam logic [PHASE_W-1:0] SLOW_LAST  = PHASE_W'(SLOW_HALF - 1);
  localparam logic [PHASE_W-1:0] FAST_LAST  = PHASE_W'(FAST_HALF - 1);
  localparam logic [PHASE_W-1:0] PULSE_LAST = PHASE_W'(PULSE_TICKS - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(GAP_TICKS - 1);

  led_cfg_t           cfg;
  logic               tick;
  logic [3:0]         pwm_cnt;
  logic               pwm_on;

  led_state_e         state,     state_nxt;
  logic [PHASE_W-1:0] phase,     phase_nxt;
  logic [3:0]         pulses,    pulses_nxt;
  logic               blink_lvl, blink_lvl_nxt;
  logic               wrap,      wrap_nxt;
  logic               pattern_on;
  logic [PHASE_W-1:0] half_last;

  led_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (bus.load),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg <= '{mode: MODE_OFF, code_len: 4'd0, brightness: 4'd15};
    end else if (bus.load) begin
      cfg <= '{mode: bus.mode, code_len: bus.code_len, brightness: bus.brightness};
    end
  end

  assign bus.cur_mode = cfg.mode;

  // The PWM counter is never cleared by load so brightness changes are glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign pwm_on    = (pwm_cnt < cfg.brightness) || (cfg.brightness == 4'hF);
  assign half_last = (cfg.mode == MODE_FAST) ? FAST_LAST : SLOW_LAST;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_STATIC;
      phase     <= '0;
      pulses    <= 4'd0;
      blink_lvl <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      pulses    <= pulses_nxt;
      blink_lvl <= blink_lvl_nxt;
      wrap      <= wrap_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    pulses_nxt    = pulses;
    blink_lvl_nxt = blink_lvl;
    wrap_nxt      = 1'b0;

    if (bus.load) begin
      state_nxt     = start_state(bus.mode, bus.code_len);
      phase_nxt     = '0;
      pulses_nxt    = 4'd0;
      blink_lvl_nxt = 1'b1;
    end else if (tick) begin
      case (state)
        S_BLINK: begin
          if (phase == half_last) begin
            phase_nxt     = '0;
            blink_lvl_nxt = ~blink_lvl;
            wrap_nxt      = ~blink_lvl;
          end else begin
            phase_nxt = phase + PHASE_W'(1);
          end
        end
        S_CODE_ON: begin
          if (phase == PULSE_LAST) begin
            phase_nxt  = '0;
            pulses_nxt = pulses + 4'd1;
            state_nxt  = S_CODE_OFF;
          end else begin
            phase_nxt = phase + PHASE_W'(1);
          end
        end
        S_CODE_OFF: begin
          if (phase == PULSE_LAST) begin
            phase_nxt = '0;
            state_nxt = (pulses == cfg.code_len) ? S_CODE_GAP : S_CODE_ON;
          end else begin
            phase_nxt = phase + PHASE_W'(1);
          end
        end
        S_CODE_GAP: begin
          if (phase == GAP_LAST) begin
            phase_nxt  = '0;
            pulses_nxt = 4'd0;
            wrap_nxt   = 1'b1;
            state_nxt  = S_CODE_ON;
          end else begin
            phase_nxt = phase + PHASE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pattern_on = 1'b0;
    case (state)
      S_STATIC:  pattern_on = (cfg.mode == MODE_ON);
      S_BLINK:   pattern_on = blink_lvl;
      S_CODE_ON: pattern_on = 1'b1;
      default:   pattern_on = 1'b0;
    endcase
  end

  // period_done trails the wrap by one cycle so it lines up with the LED's rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.led         <= 1'b0;
      bus.period_done <= 1'b0;
    end else begin
      bus.led         <= pattern_on && pwm_on;
      bus.period_done <= wrap;
    end
  end

endmodule
